// File: rtl/ibex_fp_multicycle_ctrl_pkg.sv
// ============================================================================
// Module  : ibex_fp_multicycle_ctrl_pkg
// Brief   : Shared types and rounding-mode resolution for the FP multi-cycle
//           sequencer and the decoder's illegal-instruction check.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ibex_fp_multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    I_ALU       = 3'd0,
    F_DIV       = 3'd1,
    F_ADDDIV    = 3'd2,
    INT2FLOAT32 = 3'd3
  } arithmetic_sel_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } rounding_mode_e;

  typedef enum logic [1:0] {
    FPMC_IDLE = 2'd0,
    FPMC_RUN  = 2'd1,
    FPMC_RESP = 2'd2
  } fp_mc_state_e;

  localparam int unsigned FPMC_UNIT_DIV    = 0;
  localparam int unsigned FPMC_UNIT_ADDDIV = 1;
  localparam int unsigned FPMC_UNIT_I2F    = 2;
  localparam int unsigned FPMC_NUM_UNITS   = 3;

  typedef struct packed {
    logic           legal;
    rounding_mode_e rm;
  } rm_resolved_t;

  // DYN defers to fcsr.frm; only RNE..RMM are usable once resolved.
  function automatic rm_resolved_t resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    logic [2:0]   r;
    rm_resolved_t res;
    r         = (rm == 3'b111) ? frm : rm;
    res.legal = (r <= 3'b100);
    res.rm    = rounding_mode_e'(r);
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_fp_multicycle_ctrl.sv
// ============================================================================
// Module  : ibex_fp_multicycle_ctrl
// Brief   : EX-stage sequencer that starts one multi-cycle FP unit, waits for
//           its done (with timeout) and returns the result over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_fp_multicycle_ctrl
  import ibex_fp_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TagW          = 5,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_sel_i,
  input  logic [2:0]      req_rm_i,
  input  logic [TagW-1:0] req_tag_i,
  input  logic [2:0]      frm_i,
  input  logic            kill_i,
  output logic [2:0]      unit_start_o,
  output logic [2:0]      unit_rm_o,
  output logic            unit_kill_o,
  input  logic [2:0]      unit_done_i,
  input  logic [95:0]     unit_result_i,
  input  logic [14:0]     unit_fflags_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [31:0]     resp_result_o,
  output logic [4:0]      resp_fflags_o,
  output logic [TagW-1:0] resp_tag_o,
  output logic            resp_err_o,
  output logic            busy_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  fp_mc_state_e    state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      start_q, start_d;
  logic [2:0]      rm_q, rm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     result_q, result_d;
  logic [4:0]      fflags_q, fflags_d;
  logic [TagW-1:0] tag_q, tag_d;
  logic            err_q, err_d;

  logic [2:0]      req_oh;
  logic [31:0]     mux_result;
  logic [4:0]      mux_fflags;
  logic            done_ok;
  logic            kill_unit;
  rm_resolved_t    rm_res;

  always_comb begin
    req_oh = 3'b000;
    case (req_sel_i)
      F_DIV:       req_oh[FPMC_UNIT_DIV]    = 1'b1;
      F_ADDDIV:    req_oh[FPMC_UNIT_ADDDIV] = 1'b1;
      INT2FLOAT32: req_oh[FPMC_UNIT_I2F]    = 1'b1;
      default:     req_oh = 3'b000;
    endcase
  end

  always_comb begin
    mux_result = '0;
    mux_fflags = '0;
    for (int n = 0; n < FPMC_NUM_UNITS; n++) begin
      if (sel_q[n]) begin
        mux_result = mux_result | unit_result_i[32*n +: 32];
        mux_fflags = mux_fflags | unit_fflags_i[5*n +: 5];
      end
    end
  end

  assign rm_res = resolve_rm(req_rm_i, frm_i);
  // start_q is non-zero only in the first RUN cycle, where done is not trusted.
  assign done_ok = |(unit_done_i & sel_q) && (start_q == 3'b000);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    start_d   = 3'b000;
    rm_d      = rm_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    fflags_d  = fflags_q;
    tag_d     = tag_q;
    err_d     = err_q;
    kill_unit = 1'b0;
    case (state_q)
      FPMC_IDLE: begin
        if (req_valid_i && !kill_i) begin
          tag_d = req_tag_i;
          rm_d  = rm_res.rm;
          cnt_d = '0;
          if ((|req_oh) && rm_res.legal) begin
            state_d = FPMC_RUN;
            sel_d   = req_oh;
            start_d = req_oh;
          end else begin
            state_d  = FPMC_RESP;
            sel_d    = 3'b000;
            err_d    = 1'b1;
            result_d = '0;
            fflags_d = '0;
          end
        end
      end
      FPMC_RUN: begin
        if (kill_i) begin
          kill_unit = 1'b1;
          state_d   = FPMC_IDLE;
          rm_d      = '0;
        end else if (done_ok) begin
          state_d  = FPMC_RESP;
          result_d = mux_result;
          fflags_d = mux_fflags;
          err_d    = 1'b0;
        end else if (cnt_q == CntLast) begin
          kill_unit = 1'b1;
          state_d   = FPMC_RESP;
          result_d  = '0;
          fflags_d  = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      FPMC_RESP: begin
        if (kill_i || resp_ready_i) begin
          state_d = FPMC_IDLE;
          rm_d    = '0;
        end
      end
      default: begin
        state_d = FPMC_IDLE;
        rm_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= FPMC_IDLE;
      sel_q    <= '0;
      start_q  <= '0;
      rm_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      fflags_q <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      start_q  <= start_d;
      rm_q     <= rm_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      fflags_q <= fflags_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o   = !rst_i && (state_q == FPMC_IDLE) && !kill_i;
  assign unit_start_o  = start_q;
  assign unit_rm_o     = rm_q;
  assign unit_kill_o   = kill_unit;
  assign resp_valid_o  = (state_q == FPMC_RESP);
  assign resp_result_o = result_q;
  assign resp_fflags_o = fflags_q;
  assign resp_tag_o    = tag_q;
  assign resp_err_o    = err_q;
  assign busy_o        = (state_q != FPMC_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ibex_fp_multicycle_ctrl.sv
// ============================================================================
// Module  : tb_ibex_fp_multicycle_ctrl
// Brief   : Self-checking bench for the FP multi-cycle sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibex_fp_multicycle_ctrl;
  import ibex_fp_multicycle_ctrl_pkg::*;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst, req_valid, kill, resp_ready;
  logic [2:0]  req_sel, req_rm, frm, unit_done;
  logic [4:0]  req_tag;
  logic [95:0] unit_result;
  logic [14:0] unit_fflags;
  logic        req_ready, unit_kill, resp_valid, resp_err, busy;
  logic [2:0]  unit_start, unit_rm;
  logic [31:0] resp_result;
  logic [4:0]  resp_fflags, resp_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ibex_fp_multicycle_ctrl #(.TagW(5), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_sel_i(req_sel), .req_rm_i(req_rm), .req_tag_i(req_tag), .frm_i(frm),
    .kill_i(kill),
    .unit_start_o(unit_start), .unit_rm_o(unit_rm), .unit_kill_o(unit_kill),
    .unit_done_i(unit_done), .unit_result_i(unit_result), .unit_fflags_i(unit_fflags),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_result_o(resp_result), .resp_fflags_o(resp_fflags), .resp_tag_o(resp_tag),
    .resp_err_o(resp_err), .busy_o(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic noise_units();
    unit_result = {$urandom, $urandom, $urandom};
    unit_fflags = 15'($urandom);
  endtask

  // Reference model: one request, computed from the unit-select / rounding rules
  // and the cycle budget, not from any internal state of the design.
  task automatic run_op(input logic [2:0] sel, input logic [2:0] rm, input logic [2:0] f,
                        input logic [4:0] tag, input int delay, input int rdy_wait,
                        input logic [31:0] res, input logic [4:0] ff);
    logic [2:0]  rr;
    logic [31:0] e_res;
    logic [4:0]  e_ff;
    logic        e_err, legal;
    int          unit;
    rr = (rm == 3'b111) ? f : rm;
    case (sel)
      F_DIV:       unit = 0;
      F_ADDDIV:    unit = 1;
      INT2FLOAT32: unit = 2;
      default:     unit = -1;
    endcase
    legal = (unit >= 0) && (rr <= 3'd4);

    req_valid = 1'b1; req_sel = sel; req_rm = rm; frm = f; req_tag = tag;
    resp_ready = 1'b0; unit_done = 3'b000;
    #1;
    chk("req_ready_idle", req_ready, 1'b1);
    tick();
    req_sel = 3'($urandom); req_tag = 5'($urandom); req_rm = 3'($urandom); frm = 3'($urandom);
    if (!legal) begin
      e_res = 32'd0; e_ff = 5'd0; e_err = 1'b1;
      #1;
      chk("err_no_start", unit_start, 3'b000);
      chk("err_resp_valid", resp_valid, 1'b1);
    end else begin
      unit_done = 3'b111;
      #1;
      chk("start_onehot", unit_start, 3'b001 << unit);
      chk("unit_rm", unit_rm, rr);
      chk("run_no_resp", resp_valid, 1'b0);
      chk("run_not_ready", req_ready, 1'b0);
      for (int i = 1; i <= TO - 1; i++) begin
        tick();
        noise_units();
        unit_done = 3'($urandom) & ~(3'b001 << unit);
        if (i == delay) begin
          unit_done[unit] = 1'b1;
          unit_result[32*unit +: 32] = res;
          unit_fflags[5*unit +: 5]   = ff;
        end
        #1;
        chk("unit_kill_run", unit_kill, (i == TO - 1) && (i != delay));
        chk("start_single", unit_start, 3'b000);
        if (i == delay || i == TO - 1) break;
      end
      if (delay <= TO - 1) begin
        e_res = res; e_ff = ff; e_err = 1'b0;
      end else begin
        e_res = 32'd0; e_ff = 5'd0; e_err = 1'b1;
      end
      tick();
      unit_done = 3'b000;
      #1;
      chk("resp_valid", resp_valid, 1'b1);
    end
    for (int w = 0; w <= rdy_wait; w++) begin
      if (w > 0) begin
        tick();
        noise_units();
        unit_done = 3'($urandom);
        #1;
        chk("resp_valid_held", resp_valid, 1'b1);
      end
      chk("resp_result", resp_result, e_res);
      chk("resp_fflags", resp_fflags, e_ff);
      chk("resp_err", resp_err, e_err);
      chk("resp_tag", resp_tag, tag);
      chk("resp_no_accept", req_ready, 1'b0);
      chk("resp_unit_rm", unit_rm, rr);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; req_valid = 1'b0; unit_done = 3'b000;
    #1;
    chk("idle_after_hs", resp_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_rm_zero", unit_rm, 3'b000);
    chk("idle_ready", req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; kill = 1'b0; resp_ready = 1'b0;
    req_sel = F_DIV; req_rm = RNE; frm = RNE; req_tag = 5'd0;
    unit_done = 3'b000; unit_result = '0; unit_fflags = '0;

    tick(); tick();
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", unit_start, 3'b000);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_err", resp_err, 1'b0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);
    tick();

    // Directed cases
    run_op(F_DIV, RTZ, RNE, 5'd7, 9, 0, 32'h3F800000, 5'b00001);
    run_op(INT2FLOAT32, DYN, 3'b011, 5'd3, 4, 1, 32'h4B000001, 5'b00000);
    run_op(F_DIV, DYN, 3'b101, 5'd9, 1, 0, 32'd0, 5'd0);
    run_op(I_ALU, RNE, RNE, 5'd12, 1, 3, 32'd0, 5'd0);
    run_op(F_ADDDIV, RNE, RNE, 5'd21, 1000, 0, 32'd0, 5'd0);
    run_op(F_ADDDIV, RUP, RNE, 5'd22, TO - 1, 0, 32'hDEADBEEF, 5'b10101);

    // kill_i in RUN together with done
    req_valid = 1'b1; req_sel = F_DIV; req_rm = RNE; req_tag = 5'd4;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    kill = 1'b1; unit_done = 3'b001;
    #1;
    chk("kill_run_pulse", unit_kill, 1'b1);
    tick();
    kill = 1'b0; unit_done = 3'b000;
    #1;
    chk("kill_run_pulse_len", unit_kill, 1'b0);
    chk("kill_run_no_resp", resp_valid, 1'b0);
    chk("kill_run_ready", req_ready, 1'b1);
    chk("kill_run_idle", busy, 1'b0);

    // kill_i in RESP drops the response even with resp_ready high
    req_valid = 1'b1; req_sel = I_ALU; req_tag = 5'd5;
    tick();
    req_valid = 1'b0;
    #1;
    chk("kill_resp_pre", resp_valid, 1'b1);
    kill = 1'b1; resp_ready = 1'b1;
    tick();
    kill = 1'b0; resp_ready = 1'b0;
    #1;
    chk("kill_resp_drop", resp_valid, 1'b0);
    chk("kill_resp_idle", busy, 1'b0);

    // kill_i in IDLE blocks accept
    req_valid = 1'b1; req_sel = F_DIV; kill = 1'b1;
    #1;
    chk("kill_idle_ready", req_ready, 1'b0);
    tick();
    req_valid = 1'b0; kill = 1'b0;
    #1;
    chk("kill_idle_no_accept", busy, 1'b0);
    chk("kill_idle_no_start", unit_start, 3'b000);

    // Reset mid-RUN, then a late done must be ignored
    req_valid = 1'b1; req_sel = F_ADDDIV; req_rm = RMM; req_tag = 5'd30;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstrun_busy", busy, 1'b0);
    chk("rstrun_rm", unit_rm, 3'b000);
    chk("rstrun_tag", resp_tag, 5'd0);
    chk("rstrun_valid", resp_valid, 1'b0);
    unit_done = 3'b111;
    tick();
    unit_done = 3'b000;
    #1;
    chk("late_done_ignored", resp_valid, 1'b0);
    chk("late_done_busy", busy, 1'b0);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      logic [2:0] s, r, f;
      int d;
      s = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(1, 3));
      r = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 4));
      f = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 4));
      d = ($urandom_range(0, 9) == 0) ? TO + 5 : $urandom_range(1, 20);
      run_op(s, r, f, 5'($urandom), d, $urandom_range(0, 3), $urandom, 5'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
